// File: rtl/chan_buf_arb.sv
// ---------------------------------------------------------------------------
// chan_buf_arb
//   Multi-channel buffered data path. Each of NCHAN producers pushes WIDTH-bit
//   words into its own DEPTH-entry FIFO. A round-robin arbiter drains the
//   FIFOs into one registered valid/ready output that is tagged with the
//   source channel.
//
// Optional feature macro: CHAN_BUF_LEVEL_EN
//   When defined, adds the 'level' output carrying each FIFO's occupancy.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   en         in   1              allow loading new words into the output register
//   flush      in   1              synchronous clear of FIFOs, output valid and rr pointer
//   in_valid   in   NCHAN          per-channel push request
//   in_ready   out  NCHAN          per-channel FIFO not full
//   in_data    in   NCHAN*WIDTH    channel c at [c*WIDTH +: WIDTH]
//   out_valid  out  1              output word valid
//   out_ready  in   1              consumer accepts the output word
//   out_data   out  WIDTH          output word
//   out_chan   out  CW             source channel of out_data
//   level      out  NCHAN*(AW+1)   (CHAN_BUF_LEVEL_EN only) occupancy per channel
// ---------------------------------------------------------------------------
module chan_buf_arb #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter int               NCHAN    = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '1,
  localparam int              AW       = $clog2(DEPTH),
  localparam int              CW       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic [NCHAN-1:0]        in_valid,
  output logic [NCHAN-1:0]        in_ready,
  input  logic [NCHAN*WIDTH-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CW-1:0]           out_chan
`ifdef CHAN_BUF_LEVEL_EN
  ,
  output logic [NCHAN*(AW+1)-1:0] level
`endif
);

  localparam logic [CW:0] NCHAN_W = (CW+1)'(NCHAN);

  logic [NCHAN-1:0]             empty;
  logic [NCHAN-1:0]             full;
  logic [NCHAN-1:0]             push;
  logic [NCHAN-1:0]             pop;
  logic [NCHAN-1:0][WIDTH-1:0]  head_data;

  logic [CW-1:0]                rr_ptr_reg;
  logic [CW-1:0]                rr_ptr_next;
  logic [CW-1:0]                grant;
  logic                         any_req;
  logic                         load;

  logic [2*NCHAN-1:0]           req2;
  logic [2*NCHAN-1:0]           rot_full;
  logic [NCHAN-1:0]             rot;
  logic [NCHAN-1:0]             scan;
  logic                         found;
  logic [CW-1:0]                ofs;
  logic [CW:0]                  sum;
  logic [CW:0]                  nxt;

  // -------------------------------------------------------------------------
  // Per-channel FIFOs
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW:0]      wr_ptr_reg;
      logic [AW:0]      rd_ptr_reg;

      assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

      // in_ready reflects stored state only; a pop in the same cycle does not
      // open a slot early.
      assign in_ready[gi] = ~full[gi];
      assign push[gi]     = in_valid[gi] & ~full[gi] & ~flush;
      assign pop[gi]      = load & (grant == CW'(gi));

      // Head is read combinationally; out_data is the registered stage.
      assign head_data[gi] = mem[rd_ptr_reg[AW-1:0]];

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wr_ptr_reg[AW-1:0]] <= in_data[gi*WIDTH +: WIDTH];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else if (flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

`ifdef CHAN_BUF_LEVEL_EN
      // Pointer difference is the occupancy 0..DEPTH thanks to the extra MSB.
      assign level[gi*(AW+1) +: AW+1] = wr_ptr_reg - rd_ptr_reg;
`endif
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin arbiter
  // Requests are rotated so that bit 0 corresponds to rr_ptr; the first set
  // bit gives the offset from rr_ptr to the granted channel.
  // -------------------------------------------------------------------------
  assign req2     = {~empty, ~empty};
  assign rot_full = req2 >> rr_ptr_reg;
  assign rot      = rot_full[NCHAN-1:0];
  assign any_req  = |(~empty);

  always_comb begin
    found = 1'b0;
    ofs   = '0;
    scan  = rot;
    for (int k = 0; k < NCHAN; k++) begin
      if (!found && scan[0]) begin
        found = 1'b1;
        ofs   = CW'(k);
      end
      scan = scan >> 1;
    end

    sum = {1'b0, rr_ptr_reg} + {1'b0, ofs};
    if (sum >= NCHAN_W) sum = sum - NCHAN_W;
    grant = sum[CW-1:0];

    nxt = {1'b0, grant} + 1'b1;
    if (nxt >= NCHAN_W) nxt = nxt - NCHAN_W;
    rr_ptr_next = nxt[CW-1:0];
  end

  // flush wins over any load in the same cycle.
  assign load = (!out_valid || out_ready) && en && any_req && !flush;

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= INIT_VAL;
      out_chan   <= '0;
      rr_ptr_reg <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      rr_ptr_reg <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= head_data[grant];
      out_chan   <= grant;
      rr_ptr_reg <= rr_ptr_next;
    end else if (out_ready) begin
      // Word consumed with nothing to replace it; data/chan keep last value.
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_buf_arb.sv
// ---------------------------------------------------------------------------
// tb_chan_buf_arb
//   Self-checking bench for chan_buf_arb at default parameters. Expected
//   output words ({chan, data}) are queued when stimulus is driven and
//   compared when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_chan_buf_arb;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NCHAN = 2;
  localparam int AW    = 2;
  localparam int CW    = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic                   flush = 1'b0;
  logic [NCHAN-1:0]       in_valid = '0;
  logic [NCHAN-1:0]       in_ready;
  logic [NCHAN*WIDTH-1:0] in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH-1:0]       out_data;
  logic [CW-1:0]          out_chan;
`ifdef CHAN_BUF_LEVEL_EN
  logic [NCHAN*(AW+1)-1:0] level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW+WIDTH-1:0] exp_q[$];
  logic [CW+WIDTH-1:0] exp_w;

  always #5 clk = ~clk;

  chan_buf_arb #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NCHAN(NCHAN), .INIT_VAL(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_chan(out_chan)
`ifdef CHAN_BUF_LEVEL_EN
    ,
    .level(level)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (out_data !== 8'hFF) begin n_fail++; $display("FAIL reset_out_data: got %h want ff", out_data); end
    n_tests++;
    if (out_chan !== 1'b0) begin n_fail++; $display("FAIL reset_out_chan: got %h want 0", out_chan); end
    n_tests++;
    if (in_ready !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready: got %b want 11", in_ready); end
`ifdef CHAN_BUF_LEVEL_EN
    n_tests++;
    if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %h want 0", level); end
`endif
    $display("[TB] test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_word();
    en = 1'b1;
    out_ready = 1'b1;
    in_data[7:0] = 8'hA5;
    in_valid = 2'b01;
    exp_q.push_back({1'b0, 8'hA5});
    step();                      // edge 1: push
    in_valid = 2'b00;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: out_valid got %b want 0 after edge 1", out_valid); end
    step();                      // edge 2: load
    exp_w = exp_q.pop_front();
    n_tests++;
    if ({out_valid, out_chan, out_data} !== {1'b1, exp_w}) begin
      n_fail++;
      $display("FAIL single_word: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
               out_valid, out_chan, out_data, exp_w[8], exp_w[7:0]);
    end
    step();                      // edge 3: consumed
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: out_valid got %b want 0", out_valid); end
    $display("[TB] test_single_word done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_round_robin();
    pulse_flush();
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = {8'(16 + i), 8'(i)};
      in_valid = 2'b11;
      step();
    end
    in_valid = 2'b00;
    n_tests++;
    if (in_ready !== 2'b00) begin n_fail++; $display("FAIL rr_full: in_ready got %b want 00", in_ready); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 8'(i)});
      exp_q.push_back({1'b1, 8'(16 + i)});
    end
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_w = exp_q.pop_front();
      n_tests++;
      if ({out_valid, out_chan, out_data} !== {1'b1, exp_w}) begin
        n_fail++;
        $display("FAIL rr_word%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 k, out_valid, out_chan, out_data, exp_w[8], exp_w[7:0]);
      end
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_end: out_valid got %b want 0", out_valid); end
    $display("[TB] test_round_robin done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_backpressure();
    int got;
    bit pushed6;
    pulse_flush();
    en = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data[15:8] = 8'(64 + k);
      in_valid = 2'b10;
      @(negedge clk);
      n_tests++;
      if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_push%0d: got %b want 1", k, in_ready[1]); end
      if (in_ready[1]) exp_q.push_back({1'b1, 8'(64 + k)});
      step();
    end
    in_data[15:8] = 8'h45;
    @(negedge clk);
    n_tests++;
    if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready[1] got %b want 0", in_ready[1]); end
`ifdef CHAN_BUF_LEVEL_EN
    n_tests++;
    if (level[5:3] !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", level[5:3]); end
`endif
    repeat (3) step();
    @(negedge clk);
    n_tests++;
    if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_stall: in_ready[1] got %b want 0", in_ready[1]); end
    step();
    out_ready = 1'b1;
    got = 0;
    pushed6 = 1'b0;
    for (int c = 0; c < 30 && (exp_q.size() > 0 || !pushed6); c++) begin
      @(negedge clk);
      if (in_valid[1] && in_ready[1]) begin
        exp_q.push_back({1'b1, 8'h45});
        pushed6 = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: unexpected ch=%0d d=%h", out_chan, out_data);
        end else begin
          exp_w = exp_q.pop_front();
          got++;
          if ({out_chan, out_data} !== exp_w) begin
            n_fail++;
            $display("FAIL bp_drain%0d: got ch=%0d d=%h want ch=%0d d=%h",
                     got, out_chan, out_data, exp_w[8], exp_w[7:0]);
          end
        end
      end
      step();
      if (pushed6) in_valid = 2'b00;
    end
    in_valid = 2'b00;
    n_tests++;
    if (got !== 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words (%0d pending) want 6 (0 pending)", got, exp_q.size());
    end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: out_valid got %b want 0", out_valid); end
    exp_q.delete();
    $display("[TB] test_backpressure done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall_hold();
    int npush;
    int held;
    pulse_flush();
    en = 1'b1;
    out_ready = 1'b0;
    npush = 0;
    held = 0;
    for (int c = 0; c < 14; c++) begin
      in_data[7:0] = 8'(80 + npush);
      in_valid = 2'b01;
      @(negedge clk);
      if (in_ready[0]) begin
        exp_q.push_back({1'b0, 8'(80 + npush)});
        npush++;
      end
      if (out_valid) begin
        exp_w = exp_q[0];
        held++;
        n_tests++;
        if ({out_chan, out_data} !== exp_w) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got ch=%0d d=%h want ch=%0d d=%h",
                   held, out_chan, out_data, exp_w[8], exp_w[7:0]);
        end
      end
      step();
    end
    in_valid = 2'b00;
    n_tests++;
    if (held < 10) begin n_fail++; $display("FAIL stall_cycles: held %0d want >=10", held); end
    // One-cycle accept: the head word must leave exactly once.
    out_ready = 1'b1;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_tests++;
    if ({out_valid, out_chan, out_data} !== {1'b1, exp_w}) begin
      n_fail++;
      $display("FAIL stall_accept: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
               out_valid, out_chan, out_data, exp_w[8], exp_w[7:0]);
    end
    step();
    out_ready = 1'b0;
    @(negedge clk);
    exp_w = exp_q[0];
    n_tests++;
    if ({out_valid, out_chan, out_data} !== {1'b1, exp_w}) begin
      n_fail++;
      $display("FAIL stall_next: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
               out_valid, out_chan, out_data, exp_w[8], exp_w[7:0]);
    end
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp_w = exp_q.pop_front();
        n_tests++;
        if ({out_chan, out_data} !== exp_w) begin
          n_fail++;
          $display("FAIL stall_drain: got ch=%0d d=%h want ch=%0d d=%h",
                   out_chan, out_data, exp_w[8], exp_w[7:0]);
        end
      end
      step();
    end
    n_tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: pending %0d out_valid %b want 0 and 0", exp_q.size(), out_valid);
    end
    exp_q.delete();
    $display("[TB] test_stall_hold done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush_reset();
    pulse_flush();
    en = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[7:0] = 8'(k + 1);
      in_valid = 2'b01;
      step();
      in_valid = 2'b00;
      step();
    end
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre: out_valid got %b want 1", out_valid); end
    // flush with a concurrent push on ch1 that must be discarded
    in_data[15:8] = 8'h77;
    in_valid = 2'b10;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 2'b00;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_tests++;
    if (in_ready !== 2'b11) begin n_fail++; $display("FAIL flush_in_ready: got %b want 11", in_ready); end
`ifdef CHAN_BUF_LEVEL_EN
    n_tests++;
    if (level !== '0) begin n_fail++; $display("FAIL flush_level: got %h want 0", level); end
`endif
    out_ready = 1'b1;
    repeat (3) step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: out_valid got %b want 0", out_valid); end

    // Same again with an asynchronous reset mid-cycle
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[7:0] = 8'(k + 8);
      in_valid = 2'b01;
      step();
      in_valid = 2'b00;
      step();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_tests++;
    if (out_data !== 8'hFF) begin n_fail++; $display("FAIL arst_data: got %h want ff", out_data); end
    n_tests++;
    if (in_ready !== 2'b11) begin n_fail++; $display("FAIL arst_in_ready: got %b want 11", in_ready); end
`ifdef CHAN_BUF_LEVEL_EN
    n_tests++;
    if (level !== '0) begin n_fail++; $display("FAIL arst_level: got %h want 0", level); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_empty: out_valid got %b want 0", out_valid); end
    $display("[TB] test_flush_reset done");
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_stall_hold();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
